// File: rtl/execute_unit_pkg.sv
// Shared definitions for the execute stage.
//   - op_e     : decoded operation codes driven on inOp
//   - state_e  : execute_unit control FSM encoding
//   - is_iter_op / is_legal_op : op classification helpers
package exec_pkg;

  localparam int OP_W  = 4;
  localparam int REG_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_MUL  = 4'd8,
    OP_DIVU = 4'd9,
    OP_REMU = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that run on the iterative multiply/divide sequencer.
  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_SLTU) || is_iter_op(op);
  endfunction

endpackage

// File: rtl/execute_unit_if.sv
// Operand-in / writeback-out bundle of the execute stage.
//   master : upstream issue logic (drives operands, observes writeback)
//   slave  : execute_unit
//   inValid/inReady handshake; inOp, inA, inB, inRd, inRegWrite operands;
//   RegWrite/writeReg/writeData register-file write port;
//   resultValid, illegalOp retire strobes; busy status.
interface execute_unit_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [3:0]       inOp;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [4:0]       inRd;
  logic             inRegWrite;
  logic             RegWrite;
  logic [4:0]       writeReg;
  logic [WIDTH-1:0] writeData;
  logic             resultValid;
  logic             illegalOp;
  logic             busy;

  modport master (
    output inValid, inOp, inA, inB, inRd, inRegWrite,
    input  inReady, RegWrite, writeReg, writeData, resultValid, illegalOp, busy
  );

  modport slave (
    input  inValid, inOp, inA, inB, inRd, inRegWrite,
    output inReady, RegWrite, writeReg, writeData, resultValid, illegalOp, busy
  );
endinterface

// File: rtl/execute_unit_seq_muldiv.sv
// Iterative multiply / unsigned divide sequencer, one step per cycle.
//   clk, rst : clock, synchronous active-high reset (control state only)
//   start    : load operands (a, b, op) and begin ITER steps
//   done     : high during the final step; result is valid that same cycle
//   result   : low product (MUL), quotient (DIVU) or remainder (REMU)
// Divide-by-zero is handled by the parent and never started here.
module seq_muldiv
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(ITER);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             is_rem_q, is_rem_d;
  // acc: product accumulator / partial remainder
  // quo: multiplier (shifts right) / dividend shifting into quotient
  // opb: multiplicand (shifts left) / divisor
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign done    = active_q && (cnt_q == CNT_W'(ITER - 1));
  assign shifted = {acc_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb_q};

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    is_rem_d = is_rem_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      is_div_d = (op != OP_MUL);
      is_rem_d = (op == OP_REMU);
      acc_d    = '0;
      quo_d    = a;
      opb_d    = b;
    end else if (active_q) begin
      if (is_div_q) begin
        // Restoring step: keep the subtraction only if it did not borrow.
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = acc_q + (quo_q[0] ? opb_q : '0);
        quo_d = quo_q >> 1;
        opb_d = opb_q << 1;
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (done) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end
  end

  // Result of the step being taken now, so the parent can register it on done.
  assign result = (is_div_q && !is_rem_q) ? quo_d : acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
    is_rem_q <= is_rem_d;
    acc_q    <= acc_d;
    quo_q    <= quo_d;
    opb_q    <= opb_d;
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU plus iterative MUL/DIVU/REMU, driving the
// register-file writeback triple.
//   clk, rst : clock, synchronous active-high reset
//   bus      : execute_unit_if.slave (operands in, writeback/status out)
// Flow: IDLE accepts an op; single-cycle, illegal and divide-by-zero ops go
// straight to DONE, iterative ops spend ITER cycles in BUSY. DONE lasts one
// cycle and carries the registered retire strobes.
module execute_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic           clk,
  input  logic           rst,
  execute_unit_if.slave  bus
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic [WIDTH-1:0]  write_data_q, write_data_d;
  logic              result_valid_q, result_valid_d;
  logic              illegal_q, illegal_d;

  logic              accept;
  logic              div_zero;
  logic              go_iter;
  logic              md_start;
  logic              md_done;
  logic [WIDTH-1:0]  md_result;
  logic [WIDTH-1:0]  alu_result;
  logic signed [WIDTH-1:0] a_s, b_s;

  assign accept   = bus.inValid && (state_q == ST_IDLE);
  assign div_zero = ((bus.inOp == OP_DIVU) || (bus.inOp == OP_REMU)) && (bus.inB == '0);
  assign go_iter  = is_iter_op(bus.inOp) && !div_zero;
  assign a_s      = signed'(bus.inA);
  assign b_s      = signed'(bus.inB);

  // Single-cycle results; DIVU/REMU entries cover only the divide-by-zero case.
  always_comb begin
    alu_result = '0;
    case (bus.inOp)
      OP_ADD:  alu_result = bus.inA + bus.inB;
      OP_SUB:  alu_result = bus.inA - bus.inB;
      OP_AND:  alu_result = bus.inA & bus.inB;
      OP_OR:   alu_result = bus.inA | bus.inB;
      OP_XOR:  alu_result = bus.inA ^ bus.inB;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (bus.inA < bus.inB)};
      OP_DIVU: alu_result = '1;
      OP_REMU: alu_result = bus.inA;
      default: alu_result = '0;
    endcase
  end

  seq_muldiv #(.WIDTH(WIDTH), .ITER(ITER)) u_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op     (bus.inOp),
    .a      (bus.inA),
    .b      (bus.inB),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      op_q           <= '0;
      rd_q           <= '0;
      rw_q           <= 1'b0;
      regwrite_q     <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      result_valid_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rd_q           <= rd_d;
      rw_q           <= rw_d;
      regwrite_q     <= regwrite_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      result_valid_q <= result_valid_d;
      illegal_q      <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = go_iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (md_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Retire values are computed on the edge entering DONE so every output
  // seen during DONE comes straight from a flop.
  always_comb begin
    op_d           = op_q;
    rd_d           = rd_q;
    rw_d           = rw_q;
    regwrite_d     = 1'b0;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    result_valid_d = 1'b0;
    illegal_d      = 1'b0;
    md_start       = 1'b0;
    if (state_q == ST_IDLE && accept) begin
      op_d = bus.inOp;
      rd_d = bus.inRd;
      rw_d = bus.inRegWrite;
      if (go_iter) begin
        md_start = 1'b1;
      end else begin
        result_valid_d = 1'b1;
        write_reg_d    = bus.inRd;
        illegal_d      = !is_legal_op(bus.inOp);
        write_data_d   = is_legal_op(bus.inOp) ? alu_result : '0;
        regwrite_d     = bus.inRegWrite && (bus.inRd != '0) && is_legal_op(bus.inOp);
      end
    end else if (state_q == ST_BUSY && md_done) begin
      result_valid_d = 1'b1;
      write_reg_d    = rd_q;
      write_data_d   = md_result;
      regwrite_d     = rw_q && (rd_q != '0);
    end
  end

  assign bus.inReady     = (state_q == ST_IDLE);
  assign bus.busy        = (state_q == ST_BUSY);
  assign bus.RegWrite    = regwrite_q;
  assign bus.writeReg    = write_reg_q;
  assign bus.writeData   = write_data_q;
  assign bus.resultValid = result_valid_q;
  assign bus.illegalOp   = illegal_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed testbench for execute_unit: drives on the falling edge, samples
// on the falling edge after the retiring rising edge.
module tb_execute_unit;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc;
  int   strobes;

  always #5 clk = ~clk;

  execute_unit_if #(.WIDTH(32)) bus ();

  execute_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one op for exactly one rising edge; returns at the falling
  // edge of the cycle after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw);
    @(negedge clk);
    bus.inValid    = 1'b1;
    bus.inOp       = op;
    bus.inA        = a;
    bus.inB        = b;
    bus.inRd       = rd;
    bus.inRegWrite = rw;
    @(negedge clk);
    bus.inValid    = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic rw,
                        input logic [31:0] exp_data, input logic exp_rw, input logic exp_ill);
    issue(op, a, b, rd, rw);
    chk({tag, "_valid"}, bus.resultValid, 1'b1);
    chk({tag, "_data"},  bus.writeData, exp_data);
    chk({tag, "_reg"},   bus.writeReg, rd);
    chk({tag, "_we"},    bus.RegWrite, exp_rw);
    chk({tag, "_ill"},   bus.illegalOp, exp_ill);
  endtask

  // Iterative op: checks busy status, ignores an inValid burst with changed
  // operands, and requires retirement exactly 32 cycles after BUSY begins.
  task automatic iter(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data);
    issue(op, a, b, rd, 1'b1);
    chk({tag, "_busy"},  bus.busy, 1'b1);
    chk({tag, "_ready"}, bus.inReady, 1'b0);
    cyc = 0;
    while (bus.resultValid !== 1'b1 && cyc < 64) begin
      if (cyc == 3) begin
        bus.inValid = 1'b1;
        bus.inOp    = OP_ADD;
        bus.inA     = 32'd99;
        bus.inB     = 32'd77;
        bus.inRd    = 5'd9;
      end
      if (cyc == 6) bus.inValid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"},  cyc, 32);
    chk({tag, "_data"}, bus.writeData, exp_data);
    chk({tag, "_reg"},  bus.writeReg, rd);
    chk({tag, "_we"},   bus.RegWrite, 1'b1);
    @(negedge clk);
    chk({tag, "_once"}, bus.resultValid, 1'b0);
  endtask

  initial begin
    bus.inValid    = 1'b0;
    bus.inOp       = '0;
    bus.inA        = '0;
    bus.inB        = '0;
    bus.inRd       = '0;
    bus.inRegWrite = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", bus.inReady, 1'b1);
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_we",    bus.RegWrite, 1'b0);
    chk("rst_valid", bus.resultValid, 1'b0);
    chk("rst_ill",   bus.illegalOp, 1'b0);
    chk("rst_reg",   bus.writeReg, 5'd0);
    chk("rst_data",  bus.writeData, 32'd0);
    rst = 1'b0;

    single("add", OP_ADD, 32'd5, 32'd10, 5'd3, 1'b1, 32'd15, 1'b1, 1'b0);
    @(negedge clk);
    chk("add_pulse_valid", bus.resultValid, 1'b0);
    chk("add_pulse_we",    bus.RegWrite, 1'b0);
    chk("add_hold_data",   bus.writeData, 32'd15);
    chk("add_hold_reg",    bus.writeReg, 5'd3);
    chk("add_idle_ready",  bus.inReady, 1'b1);

    single("sub",   OP_SUB,  32'd5, 32'd10, 5'd6, 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0);
    single("slt",   OP_SLT,  32'd5, 32'd10, 5'd7, 1'b1, 32'd1, 1'b1, 1'b0);
    single("sltneg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1, 32'd1, 1'b1, 1'b0);
    single("sltu",  OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd8, 1'b1, 32'd0, 1'b1, 1'b0);
    single("and",   OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 5'd9, 1'b1, 32'h0000_F000, 1'b1, 1'b0);
    single("or",    OP_OR,   32'h0000_F0F0, 32'h0000_FF00, 5'd9, 1'b1, 32'h0000_FFF0, 1'b1, 1'b0);
    single("xor",   OP_XOR,  32'h0000_F0F0, 32'h0000_FF00, 5'd9, 1'b1, 32'h0000_0FF0, 1'b1, 1'b0);
    single("addwrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 5'd2, 1'b1, 32'd1, 1'b1, 1'b0);

    iter("mul",    OP_MUL,  32'd5, 32'd10, 5'd4, 32'd50);
    iter("mulbig", OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'd1);
    iter("mulsh",  OP_MUL,  32'h1234_5678, 32'h10, 5'd5, 32'h2345_6780);
    iter("divu",   OP_DIVU, 32'd10, 32'd5, 5'd10, 32'd2);
    iter("remu",   OP_REMU, 32'd10, 32'd3, 5'd11, 32'd1);
    iter("divu7",  OP_DIVU, 32'd100, 32'd7, 5'd12, 32'd14);
    iter("remu7",  OP_REMU, 32'd100, 32'd7, 5'd13, 32'd2);
    iter("divmax", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 5'd14, 32'h7FFF_FFFF);

    single("divz", OP_DIVU, 32'd10, 32'd0, 5'd15, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    single("remz", OP_REMU, 32'd10, 32'd0, 5'd16, 1'b1, 32'd10, 1'b1, 1'b0);

    single("rd0",   OP_ADD, 32'd1, 32'd2, 5'd0, 1'b1, 32'd3, 1'b0, 1'b0);
    single("nowe",  OP_ADD, 32'd1, 32'd2, 5'd7, 1'b0, 32'd3, 1'b0, 1'b0);
    single("ill",   4'd15,  32'd1, 32'd2, 5'd5, 1'b1, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ill_pulse", bus.illegalOp, 1'b0);

    // Reset while the sequencer is on iteration 10.
    issue(OP_MUL, 32'd5, 32'd10, 5'd4, 1'b1);
    repeat (10) @(negedge clk);
    chk("mrst_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", bus.inReady, 1'b1);
    chk("mrst_busy",  bus.busy, 1'b0);
    chk("mrst_we",    bus.RegWrite, 1'b0);
    chk("mrst_valid", bus.resultValid, 1'b0);
    chk("mrst_ill",   bus.illegalOp, 1'b0);
    chk("mrst_data",  bus.writeData, 32'd0);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.RegWrite !== 1'b0 || bus.resultValid !== 1'b0) strobes++;
    end
    chk("mrst_no_retire", strobes, 0);

    single("post_rst", OP_ADD, 32'd7, 32'd8, 5'd1, 1'b1, 32'd15, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
Execute stage directly downstream of the register file. It consumes the two read operands plus a decoded op, destination register and write enable. It computes the result and drives the writeback triple (RegWrite, writeReg, writeData), which connects straight back to the register file write port. Logic ops complete in one cycle; multiply, divide and remainder use an iterative 32-step sequencer.

Parameters:
WIDTH, 32, datapath width (only 32 is verified)
ITER, 32, iterations for MUL/DIVU/REMU (must equal WIDTH)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
inValid  in  1  operands/op valid this cycle
inReady  out  1  block can accept an op (high only in IDLE)
inOp  in  4  operation code (see package)
inA  in  WIDTH  operand A (readData1)
inB  in  WIDTH  operand B (readData2)
inRd  in  5  destination register
inRegWrite  in  1  op writes a register
RegWrite  out  1  one-cycle write strobe to register file
writeReg  out  5  destination register
writeData  out  WIDTH  result
resultValid  out  1  one-cycle pulse when any op retires
illegalOp  out  1  one-cycle pulse with resultValid for an undefined inOp
busy  out  1  high in BUSY state

Behaviour:
- Reset: synchronous, active-high. State=IDLE. inReady=1 after reset. RegWrite, resultValid, illegalOp, busy=0. writeReg=0, writeData=0, iteration counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Accept when inValid && inReady; latch op, A, B, rd, regWrite.
  - Single-cycle op or illegal op -> DONE.
  - MUL/DIVU/REMU -> BUSY with count=0, except a divisor of 0 -> DONE directly.
- BUSY:
  - One shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle; count increments.
  - At count==ITER-1 -> DONE.
  - inValid is ignored; inReady=0.
- DONE (exactly one cycle):
  - resultValid=1.
  - writeData and writeReg are valid.
  - RegWrite = latched regWrite && rd!=0 && op legal.
  - Then -> IDLE.
- Outputs are registered. writeData and writeReg hold their last value after DONE; RegWrite, resultValid and illegalOp are pulses.
- Latency, with acceptance at edge N:
  - Single-cycle op: DONE in cycle N+1.
  - Iterative op: BUSY for cycles N+1..N+32, DONE in cycle N+33.
  - Throughput is at most one op per 2 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^32; no overflow flag.
  - SLT is signed and yields 0 or 1. SLTU is unsigned.
  - AND, OR, XOR are bitwise.
  - MUL yields the low 32 bits of the product.
  - DIVU/REMU are unsigned.
- Divide by zero: DIVU -> 0xFFFFFFFF; REMU -> dividend. Both retire one cycle after acceptance.
- Illegal op: writeData=0, illegalOp=1, RegWrite=0.
- Reset during BUSY or DONE: operation abandoned; no RegWrite pulse after reset.
- Operands are latched at acceptance; later changes on inA/inB have no effect.

Decomposition:
- Shared package exec_pkg:
  - Op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, MUL=8, DIVU=9, REMU=10.
  - State encoding.
  - Helper constant for "is iterative op".
- One sub-module seq_muldiv:
  - Holds the accumulator, quotient/remainder registers and iteration counter.
  - Handshake to the parent: start, done.
- execute_unit owns the FSM, the single-cycle ALU and the writeback registers.

Test Plan:
- ADD, A=5, B=10, rd=3, regWrite=1 -> next cycle: RegWrite=1, writeReg=3, writeData=15, resultValid=1.
- SUB A=5, B=10 -> 0xFFFFFFFB. SLT on the same operands -> 1. SLTU A=0xFFFFFFFF, B=1 -> 0.
- MUL A=5, B=10, rd=4 -> busy for 32 cycles; DONE on cycle 33 with writeData=50. inValid pulses during BUSY are not accepted.
- DIVU A=10, B=5 -> 2. REMU A=10, B=3 -> 1. DIVU A=10, B=0 -> 0xFFFFFFFF one cycle after accept. REMU A=10, B=0 -> 10.
- ADD with rd=0, regWrite=1 -> resultValid=1, RegWrite=0. inOp=15 -> illegalOp=1, writeData=0, RegWrite=0.
- Start MUL, assert rst at BUSY count 10 -> next cycle: state IDLE, inReady=1, all strobes 0. No RegWrite pulse for the following 40 cycles.
